karplus_strong_voice: RTL and testbench

//  Parametrised Karplus-Strong plucked-string voice with an Avalon-MM slave for Nios II control. Single clock domain.

---
 rtl/ks_pkg.sv | 28 ++
 rtl/ks_delay_ram.sv | 25 ++
 rtl/karplus_strong_voice.sv | 242 ++++++++++++++++++++++++
 tb/tb_karplus_strong_voice.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong voice: register map, FSM states,
// LFSR constants and the Galois LFSR step used while filling the delay line.
package ks_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_LENGTH   = 3'd1;
  localparam logic [2:0] ADDR_DIV      = 3'd2;
  localparam logic [2:0] ADDR_DECAY    = 3'd3;
  localparam logic [2:0] ADDR_SEED     = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_DURATION = 3'd6;
  localparam logic [2:0] ADDR_SAMPLE   = 3'd7;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [31:0] MIN_DIV      = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/ks_delay_ram.sv
// Circular delay-line storage: one write port and one registered read port,
// written so synthesis maps it onto block RAM.
module ks_delay_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/karplus_strong_voice.sv
// Karplus-Strong plucked-string voice: Avalon-MM register file, sample-tick
// divider, noise-fill/run FSM and averaging decay filter around a RAM delay line.
module karplus_strong_voice
  import ks_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid
);

  localparam logic [LEN_W:0] MAX_LEN_L = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0] MIN_LEN_L = (LEN_W+1)'(2);

  state_t             state_q, state_d;
  logic               enable_q, enable_d, irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
  logic [LEN_W:0]     length_q, length_d, act_len_q, act_len_d;
  logic [31:0]        div_q, div_d, div_cnt_q, div_cnt_d, duration_q, duration_d;
  logic [31:0]        remain_q, remain_d;
  logic [15:0]        decay_q, decay_d, seed_q, seed_d, lfsr_q, lfsr_d;
  logic [LEN_W-1:0]   ptr_q, ptr_d, p1_addr_q, p1_addr_d, wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  z_q, z_d, sample_q, sample_d;
  logic               p1_valid_q, p1_valid_d, sample_valid_q, sample_valid_d;

  logic               bus_wr, pluck, tick, irq_set, fill_last, ptr_last;
  logic [31:0]        div_eff;
  logic [DATA_W-1:0]  rd_data, fill_word, y, ram_wdata;
  logic [LEN_W-1:0]   ram_waddr;
  logic               ram_we;

  logic signed [DATA_W-1:0] x_s, z_s;
  logic signed [DATA_W:0]   sum_s;
  logic signed [16:0]       gain_s;
  logic signed [DATA_W+17:0] prod_s;

  assign bus_wr    = chipselect & write;
  assign pluck     = bus_wr && (address == ADDR_CTRL) && writedata[2];
  assign fill_last = ({1'b0, ptr_q} == (act_len_q - (LEN_W+1)'(1)));
  assign ptr_last  = fill_last;

  assign div_eff   = (div_q < MIN_DIV) ? MIN_DIV : div_q;
  assign tick      = enable_q && (div_cnt_q >= div_eff);
  assign div_cnt_d = (!enable_q || tick) ? 32'd0 : div_cnt_q + 32'd1;

  // Filter: y = ((x + z) * g) >>> 17, sized so the product cannot overflow.
  assign x_s    = rd_data;
  assign z_s    = z_q;
  assign gain_s = {1'b0, decay_q};
  assign sum_s  = (DATA_W+1)'(x_s) + (DATA_W+1)'(z_s);
  assign prod_s = (DATA_W+18)'(sum_s) * (DATA_W+18)'(gain_s);
  assign y      = DATA_W'(prod_s >>> 17);

  always_comb begin
    fill_word = '0;
    fill_word[DATA_W-1 -: 16] = lfsr_q;
  end

  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    length_d   = length_q;
    div_d      = div_q;
    decay_d    = decay_q;
    seed_d     = seed_q;
    duration_d = duration_q;
    irq_pend_d = irq_pend_q;
    if (bus_wr) begin
      case (address)
        ADDR_CTRL: begin
          enable_d = writedata[0];
          irq_en_d = writedata[1];
        end
        ADDR_LENGTH: begin
          if (writedata < 32'd2)               length_d = MIN_LEN_L;
          else if (writedata > 32'(MAX_LEN))   length_d = MAX_LEN_L;
          else                                 length_d = writedata[LEN_W:0];
        end
        ADDR_DIV:      div_d      = writedata;
        ADDR_DECAY:    decay_d    = writedata[15:0];
        ADDR_SEED:     seed_d     = (writedata[15:0] == 16'd0) ? DEFAULT_SEED : writedata[15:0];
        ADDR_STATUS:   if (writedata[2]) irq_pend_d = 1'b0;
        ADDR_DURATION: duration_d = writedata;
        default: ;
      endcase
    end
    // A hardware set in the same clock as a software clear must win.
    if (irq_set) irq_pend_d = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    ptr_d          = ptr_q;
    z_d            = z_q;
    act_len_d      = act_len_q;
    remain_d       = remain_q;
    p1_valid_d     = 1'b0;
    p1_addr_d      = p1_addr_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    wb_addr_d      = wb_addr_q;
    irq_set        = 1'b0;

    // Second pipeline stage; a pluck cancels any sample still in flight.
    if (p1_valid_q && !pluck) begin
      sample_d       = y;
      sample_valid_d = 1'b1;
      wb_addr_d      = p1_addr_q;
      z_d            = rd_data;
    end

    case (state_q)
      ST_FILL: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (fill_last) begin
          ptr_d   = '0;
          state_d = ST_RUN;
        end else begin
          ptr_d = ptr_q + LEN_W'(1);
        end
      end
      ST_RUN: begin
        if (!pluck && tick) begin
          p1_valid_d = 1'b1;
          p1_addr_d  = ptr_q;
          ptr_d      = ptr_last ? '0 : ptr_q + LEN_W'(1);
          if (remain_q != 32'd0) begin
            remain_d = remain_q - 32'd1;
            if (remain_q == 32'd1) begin
              state_d = ST_IDLE;
              irq_set = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    if (pluck && (state_q != ST_FILL)) begin
      state_d   = ST_FILL;
      lfsr_d    = seed_q;
      ptr_d     = '0;
      z_d       = '0;
      act_len_d = length_q;
      remain_d  = duration_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      irq_pend_q     <= 1'b0;
      length_q       <= MAX_LEN_L;
      act_len_q      <= MAX_LEN_L;
      div_q          <= '0;
      div_cnt_q      <= '0;
      duration_q     <= '0;
      remain_q       <= '0;
      decay_q        <= '0;
      seed_q         <= DEFAULT_SEED;
      lfsr_q         <= DEFAULT_SEED;
      ptr_q          <= '0;
      p1_addr_q      <= '0;
      wb_addr_q      <= '0;
      z_q            <= '0;
      sample_q       <= '0;
      p1_valid_q     <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      irq_pend_q     <= irq_pend_d;
      length_q       <= length_d;
      act_len_q      <= act_len_d;
      div_q          <= div_d;
      div_cnt_q      <= div_cnt_d;
      duration_q     <= duration_d;
      remain_q       <= remain_d;
      decay_q        <= decay_d;
      seed_q         <= seed_d;
      lfsr_q         <= lfsr_d;
      ptr_q          <= ptr_d;
      p1_addr_q      <= p1_addr_d;
      wb_addr_q      <= wb_addr_d;
      z_q            <= z_d;
      sample_q       <= sample_d;
      p1_valid_q     <= p1_valid_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  // Fill owns the write port; write-back lands two clocks after its tick.
  assign ram_we    = (state_q == ST_FILL) || sample_valid_q;
  assign ram_waddr = (state_q == ST_FILL) ? ptr_q : wb_addr_q;
  assign ram_wdata = (state_q == ST_FILL) ? fill_word : sample_q;

  ks_delay_ram #(
    .DATA_W(DATA_W),
    .DEPTH (MAX_LEN),
    .ADDR_W(LEN_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata),
    .rd_addr(ptr_q),
    .rd_data(rd_data)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:     readdata = {30'd0, irq_en_q, enable_q};
      ADDR_LENGTH:   readdata = 32'(length_q);
      ADDR_DIV:      readdata = div_q;
      ADDR_DECAY:    readdata = {16'd0, decay_q};
      ADDR_SEED:     readdata = {16'd0, seed_q};
      ADDR_STATUS:   readdata = {29'd0, irq_pend_q, state_q == ST_RUN, state_q == ST_FILL};
      ADDR_DURATION: readdata = duration_q;
      ADDR_SAMPLE:   readdata = 32'($signed(sample_q));
      default: ;
    endcase
  end

  assign irq          = irq_pend_q & irq_en_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_karplus_strong_voice.sv
// Directed self-checking bench for karplus_strong_voice with a bit-exact
// reference model of the delay line and decay filter.
module tb_karplus_strong_voice;

  localparam logic [2:0] A_CTRL = 3'd0, A_LENGTH = 3'd1, A_DIV = 3'd2, A_DECAY = 3'd3;
  localparam logic [2:0] A_SEED = 3'd4, A_STATUS = 3'd5, A_DURATION = 3'd6, A_SAMPLE = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, write;
  logic [31:0] writedata, readdata;
  logic        irq, sample_valid;
  logic [15:0] sample_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] fill_ref [5] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
  logic [31:0] reset_ref [8] = '{32'h0, 32'd1024, 32'h0, 32'h0, 32'hACE1, 32'h0, 32'h0, 32'h0};

  logic [15:0]        m_ram [1024];
  int                 m_ptr, m_len;
  logic signed [15:0] m_z;
  logic [15:0]        m_g;

  always #5 clk = ~clk;

  karplus_strong_voice dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .sample_out  (sample_out),
    .sample_valid(sample_valid)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic check_reset_regs(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      reg_read(3'(i), d);
      check_output($sformatf("%s reg %0d", tag, i), d, reset_ref[i]);
    end
    check_output({tag, " irq"}, 32'(irq), 32'd0);
    check_output({tag, " sample_valid"}, 32'(sample_valid), 32'd0);
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_pluck(input int len, input logic [15:0] seed);
    logic [15:0] s;
    s = seed;
    m_len = len; m_ptr = 0; m_z = '0;
    for (int i = 0; i < len; i++) begin
      m_ram[i] = s;
      s = ref_lfsr(s);
    end
  endtask

  task automatic model_step(output logic [15:0] yv);
    logic signed [15:0] x;
    longint p;
    x = m_ram[m_ptr];
    p = (longint'(x) + longint'(m_z)) * longint'({48'd0, m_g});
    yv = 16'(p >>> 17);
    m_ram[m_ptr] = yv;
    m_z = x;
    m_ptr = (m_ptr + 1) % m_len;
  endtask

  task automatic wait_sample(output logic [15:0] val, output int gap, output bit ok);
    gap = 0; ok = 0; val = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      gap++;
      if (sample_valid) begin
        ok = 1; val = sample_out;
        break;
      end
    end
  endtask

  task automatic run_ticks(input int n, input int period, input string tag);
    logic [15:0] got, exp;
    int gap;
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_sample(got, gap, ok);
      check_output($sformatf("%s arrival %0d", tag, k), 32'(ok), 32'd1);
      if (!ok) return;
      model_step(exp);
      check_output($sformatf("%s sample %0d", tag, k), 32'(got), 32'(exp));
      if (k > 0) check_output($sformatf("%s gap %0d", tag, k), 32'(gap), 32'(period));
    end
  endtask

  task automatic count_fill(input int exp_len, input string tag);
    int n;
    bit seen_valid, done;
    logic [15:0] held;
    n = 0; seen_valid = 0; done = 0;
    address = A_STATUS;
    held = sample_out;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (readdata[0]) begin
        n++;
        if (sample_valid) seen_valid = 1;
      end else begin
        done = 1;
      end
    end
    check_output({tag, " fill clocks"}, 32'(n), 32'(exp_len));
    check_output({tag, " running after fill"}, 32'(readdata[1]), 32'd1);
    check_output({tag, " no valid in fill"}, 32'(seen_valid), 32'd0);
    check_output({tag, " sample held"}, 32'(sample_out), 32'(held));
  endtask

  task automatic check_fill_ram(input string tag);
    for (int i = 0; i < 5; i++)
      check_output($sformatf("%s ram %0d", tag, i), 32'(dut.u_ram.mem[i]), 32'(fill_ref[i]));
  endtask

  task automatic apply_stimulus();
    logic [31:0] d;
    int pulses;

    // Reset state
    reset = 1'b0; address = '0; chipselect = 1'b0; write = 1'b0; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_reset_regs("reset");
    reg_write(A_SEED, 32'd0);
    reg_read(A_SEED, d);
    check_output("seed zero", d, 32'hACE1);

    // Fill with length 5, seed 1
    reg_write(A_LENGTH, 32'd5);
    reg_write(A_SEED, 32'd1);
    reg_write(A_CTRL, 32'd4);
    count_fill(5, "fill5");
    check_fill_ram("fill5");
    model_pluck(5, 16'h0001);

    // Run 50 ticks at period 10 with full gain
    m_g = 16'hFFFF;
    reg_write(A_DIV, 32'd9);
    reg_write(A_DECAY, 32'hFFFF);
    reg_write(A_CTRL, 32'd1);
    run_ticks(50, 10, "div9");

    // Duration-limited note raising irq
    reg_write(A_DURATION, 32'd20);
    reg_write(A_CTRL, 32'd7);
    model_pluck(5, 16'h0001);
    count_fill(5, "dur");
    run_ticks(20, 10, "dur");
    check_output("dur irq", 32'(irq), 32'd1);
    reg_read(A_STATUS, d);
    check_output("dur status", d, 32'd4);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    check_output("idle no valid", 32'(pulses), 32'd0);
    reg_write(A_STATUS, 32'd4);
    check_output("irq cleared", 32'(irq), 32'd0);
    reg_read(A_STATUS, d);
    check_output("status cleared", d, 32'd0);

    // Length clamps and minimum tick period
    reg_write(A_DURATION, 32'd0);
    reg_write(A_LENGTH, 32'd0);
    reg_read(A_LENGTH, d);
    check_output("len clamp low", d, 32'd2);
    reg_write(A_DIV, 32'd0);
    reg_write(A_CTRL, 32'd5);
    model_pluck(2, 16'h0001);
    count_fill(2, "len2");
    run_ticks(20, 4, "len2");
    reg_write(A_LENGTH, 32'd3000);
    reg_read(A_LENGTH, d);
    check_output("len clamp high", d, 32'd1024);
    reg_write(A_CTRL, 32'd5);
    model_pluck(1024, 16'h0001);
    count_fill(1024, "len1024");
    check_output("len1024 ram last", 32'(dut.u_ram.mem[1023]), 32'(m_ram[1023]));
    run_ticks(10, 4, "len1024");

    // Pluck mid-run restarts fill from ptr 0
    reg_write(A_LENGTH, 32'd5);
    reg_write(A_CTRL, 32'd5);
    model_pluck(5, 16'h0001);
    count_fill(5, "repluck");
    check_fill_ram("repluck");
    run_ticks(5, 4, "repluck");

    // Reset mid-fill
    reg_write(A_CTRL, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    address = A_STATUS;
    #1;
    check_output("rst status", readdata, 32'd0);
    check_output("rst irq", 32'(irq), 32'd0);
    check_output("rst sample", 32'(sample_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check_reset_regs("midreset");
    reg_write(A_LENGTH, 32'd5);
    reg_write(A_SEED, 32'd1);
    reg_write(A_CTRL, 32'd4);
    count_fill(5, "postreset");
    check_fill_ram("postreset");
  endtask

  initial begin
    m_g = '0; m_ptr = 0; m_len = 2; m_z = '0;
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
